// File: rtl/cnn_accel_pkg.sv
// ============================================================================
// cnn_accel_pkg - shared constants, FSM encoding and row helpers for the tile
// Rev 1.0
// ============================================================================
`default_nettype none

package cnn_accel_pkg;

    localparam logic [7:0] INSTR_COMPUTE    = 8'd87;
    localparam logic [7:0] INSTR_LOADIFMAPS = 8'd88;

    localparam logic [1:0] REG_CTRL0  = 2'd0;
    localparam logic [1:0] REG_CTRL1  = 2'd1;
    localparam logic [1:0] REG_CTRL2  = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam logic [1:0] FUNC_CONV = 2'd0;
    localparam logic [1:0] FUNC_POOL = 2'd1;

    localparam int PSUM_W = 5;
    localparam int KMAX   = 5;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    typedef logic [KMAX-1:0][KMAX-1:0] rows_t;

    function automatic logic [2:0] ksize_decode(input logic [4:0] oh);
        case (oh)
            5'b00001: return 3'd1;
            5'b00010: return 3'd2;
            5'b00100: return 3'd3;
            5'b01000: return 3'd4;
            default:  return 3'd5;
        endcase
    endfunction

    function automatic logic [4:0] row_mask(input logic [2:0] k);
        logic [5:0] m;
        m = (6'd1 << k) - 6'd1;
        return m[4:0];
    endfunction

    // Rows 0..k-1 form the live buffer: row 0 is oldest, the beat lands in row k-1.
    function automatic rows_t shift_rows(input rows_t rows, input logic [4:0] beat,
                                         input logic [2:0] k);
        rows_t r;
        r = rows;
        for (int i = 0; i < KMAX; i++) begin
            if (3'(i) + 3'd1 == k)
                r[i] = beat;
            else if (3'(i) + 3'd1 < k)
                r[i] = rows[(i + 1) % KMAX];
        end
        return r;
    endfunction

    function automatic logic [2:0] popcount5(input logic [4:0] a);
        logic [2:0] c;
        c = '0;
        for (int i = 0; i < 5; i++)
            c = c + 3'(a[i]);
        return c;
    endfunction

endpackage

`default_nettype wire

// File: rtl/axil_ctrl_regs.sv
// ============================================================================
// axil_ctrl_regs - AXI4-Lite slave holding CTRL0/CTRL1/CTRL2/STATUS
// Rev 1.0
// ============================================================================
`default_nettype none

module axil_ctrl_regs
    import cnn_accel_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ADDR_W-1:0]   awaddr,
    input  logic                awvalid,
    output logic                awready,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                wvalid,
    output logic                wready,
    output logic [1:0]          bresp,
    output logic                bvalid,
    input  logic                bready,
    input  logic [ADDR_W-1:0]   araddr,
    input  logic                arvalid,
    output logic                arready,
    output logic [DATA_W-1:0]   rdata,
    output logic [1:0]          rresp,
    output logic                rvalid,
    input  logic                rready,
    input  state_t              fsm_state,
    output logic                start,
    output logic [11:0]         ofmaps_channel,
    output logic [1:0]          func,
    output logic [8:0]          ofmaps_width,
    output logic [4:0]          ksize_oh
);

    logic [31:0] ctrl0;
    logic [10:0] ctrl1;
    logic        done;
    logic        wr_en;
    logic [1:0]  wr_sel;
    logic [7:0]  instr_new;
    logic [31:0] rd_val;
    logic        unused_ok;

    assign wr_en          = awready && wready && awvalid && wvalid;
    assign wr_sel         = awaddr[3:2];
    assign instr_new      = wstrb[0] ? wdata[7:0] : ctrl0[7:0];
    assign start          = wr_en && (wr_sel == REG_CTRL0) &&
                            (instr_new == INSTR_COMPUTE) && (fsm_state == ST_IDLE);
    assign ofmaps_channel = ctrl0[31:20];
    assign func           = ctrl1[1:0];
    assign ofmaps_width   = ctrl1[10:2];
    assign bresp          = 2'b00;
    assign rresp          = 2'b00;
    assign unused_ok      = ^{awaddr[1:0], araddr[1:0]};

    // Ready is withheld while a response is pending so a held VALID is taken only once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            awready <= 1'b0;
            wready  <= 1'b0;
            bvalid  <= 1'b0;
        end else begin
            if (!awready && awvalid && wvalid && !bvalid) begin
                awready <= 1'b1;
                wready  <= 1'b1;
            end else begin
                awready <= 1'b0;
                wready  <= 1'b0;
            end
            if (wr_en)
                bvalid <= 1'b1;
            else if (bready)
                bvalid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl0    <= '0;
            ctrl1    <= '0;
            ksize_oh <= '0;
            done     <= 1'b0;
        end else begin
            if (fsm_state == ST_DONE) begin
                done       <= 1'b1;
                ctrl0[7:0] <= 8'd0;
            end else if (start) begin
                done <= 1'b0;
            end
            if (wr_en) begin
                case (wr_sel)
                    REG_CTRL0: begin
                        for (int b = 0; b < 4; b++)
                            if (wstrb[b]) ctrl0[8*b +: 8] <= wdata[8*b +: 8];
                    end
                    REG_CTRL1: begin
                        if (wstrb[0]) ctrl1[7:0]  <= wdata[7:0];
                        if (wstrb[1]) ctrl1[10:8] <= wdata[10:8];
                    end
                    REG_CTRL2: begin
                        if (wstrb[0]) ksize_oh <= wdata[4:0];
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        rd_val = 32'd0;
        case (araddr[3:2])
            REG_CTRL0: rd_val = ctrl0;
            REG_CTRL1: rd_val = {21'd0, ctrl1};
            REG_CTRL2: rd_val = {26'd0, done, ksize_oh};
            default:   rd_val = {29'd0, fsm_state, done};
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rdata   <= '0;
        end else begin
            arready <= !arready && arvalid && !rvalid;
            if (arready && arvalid) begin
                rvalid <= 1'b1;
                rdata  <= DATA_W'(rd_val);
            end else if (rready) begin
                rvalid <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/cnn_accel_top.sv
// ============================================================================
// cnn_accel_top - binary convolution / pooling tile with AXI-Lite control
// Rev 1.0
// ============================================================================
`default_nettype none

module cnn_accel_top
    import cnn_accel_pkg::*;
#(
    parameter int MAC_NUM              = 256,
    parameter int BRAM_ADDRESS_WIDTH   = 12,
    parameter int C_S_AXIS_TDATA_WIDTH = 32,
    parameter int C_S_AXI_DATA_WIDTH   = 32,
    parameter int C_S_AXI_ADDR_WIDTH   = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [C_S_AXIS_TDATA_WIDTH-1:0]   S_AXIS_TDATA,
    input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0] S_AXIS_TSTRB,
    input  logic                              S_AXIS_TLAST,
    input  logic                              S_AXIS_TVALID,
    output logic                              S_AXIS_TREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    output logic [MAC_NUM*PSUM_W-1:0]         psum_out
);

    localparam int          LANE_W = $clog2(MAC_NUM) + 1;
    localparam logic [20:0] N_MAX  = 21'(MAC_NUM);

    state_t              state;
    rows_t               kern, win, kern_next, win_next;
    logic [2:0]          ksz, win_cnt;
    logic [4:0]          kmask, beat, ksize_oh;
    logic [LANE_W-1:0]   lane_idx;
    logic [11:0]         ofmaps_channel;
    logic [8:0]          ofmaps_width;
    logic [1:0]          func;
    logic                start, beat_fire, win_full, last_psum, psum_we, pool_any;
    logic [20:0]         n_prod, n_target;
    logic [PSUM_W-1:0]   conv_sum, psum;
    logic                unused_ok;

    axil_ctrl_regs #(
        .DATA_W (C_S_AXI_DATA_WIDTH),
        .ADDR_W (C_S_AXI_ADDR_WIDTH)
    ) u_regs (
        .clk            (clk),
        .rst_n          (rst_n),
        .awaddr         (S_AXI_AWADDR),
        .awvalid        (S_AXI_AWVALID),
        .awready        (S_AXI_AWREADY),
        .wdata          (S_AXI_WDATA),
        .wstrb          (S_AXI_WSTRB),
        .wvalid         (S_AXI_WVALID),
        .wready         (S_AXI_WREADY),
        .bresp          (S_AXI_BRESP),
        .bvalid         (S_AXI_BVALID),
        .bready         (S_AXI_BREADY),
        .araddr         (S_AXI_ARADDR),
        .arvalid        (S_AXI_ARVALID),
        .arready        (S_AXI_ARREADY),
        .rdata          (S_AXI_RDATA),
        .rresp          (S_AXI_RRESP),
        .rvalid         (S_AXI_RVALID),
        .rready         (S_AXI_RREADY),
        .fsm_state      (state),
        .start          (start),
        .ofmaps_channel (ofmaps_channel),
        .func           (func),
        .ofmaps_width   (ofmaps_width),
        .ksize_oh       (ksize_oh)
    );

    assign unused_ok = ^{S_AXIS_TDATA[C_S_AXIS_TDATA_WIDTH-1:5], S_AXIS_TSTRB, S_AXIS_TLAST,
                         S_AXI_AWPROT, S_AXI_ARPROT, 32'(BRAM_ADDRESS_WIDTH)};

    assign beat_fire = S_AXIS_TVALID && S_AXIS_TREADY;
    assign ksz       = ksize_decode(ksize_oh);
    assign kmask     = row_mask(ksz);
    assign beat      = S_AXIS_TDATA[4:0] & kmask;
    assign kern_next = shift_rows(kern, beat, ksz);
    assign win_next  = shift_rows(win, beat, ksz);
    assign win_full  = (win_cnt >= ksz - 3'd1);
    assign n_prod    = 21'(ofmaps_width) * 21'(ofmaps_channel);
    assign n_target  = (n_prod == 21'd0) ? 21'd1 : ((n_prod > N_MAX) ? N_MAX : n_prod);
    assign last_psum = (21'(lane_idx) + 21'd1) >= n_target;
    assign psum_we   = (state == ST_COMPUTE) && beat_fire && win_full;

    // The psum is taken on the window including the current beat; rows and bits past K are masked.
    always_comb begin
        conv_sum = '0;
        pool_any = 1'b0;
        for (int i = 0; i < KMAX; i++) begin
            if (3'(i) < ksz) begin
                conv_sum = conv_sum + PSUM_W'(popcount5(kern[i] & win_next[i] & kmask));
                pool_any = pool_any | (|(win_next[i] & kmask));
            end
        end
        psum = (func == FUNC_POOL) ? PSUM_W'(pool_any) : conv_sum;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            S_AXIS_TREADY <= 1'b0;
            kern          <= '0;
            win           <= '0;
            win_cnt       <= '0;
            lane_idx      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    S_AXIS_TREADY <= 1'b1;
                    if (beat_fire)
                        kern <= kern_next;
                    if (start) begin
                        state    <= ST_COMPUTE;
                        win_cnt  <= '0;
                        lane_idx <= '0;
                    end
                end
                ST_COMPUTE: begin
                    if (beat_fire) begin
                        win <= win_next;
                        if (!win_full) begin
                            win_cnt <= win_cnt + 3'd1;
                        end else begin
                            lane_idx <= lane_idx + 1'b1;
                            if (last_psum) begin
                                state         <= ST_DONE;
                                S_AXIS_TREADY <= 1'b0;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    state         <= ST_IDLE;
                    S_AXIS_TREADY <= 1'b1;
                end
                default: begin
                    state         <= ST_IDLE;
                    S_AXIS_TREADY <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            psum_out <= '0;
        else if (psum_we)
            psum_out[int'(lane_idx) * PSUM_W +: PSUM_W] <= psum;
    end

endmodule

`default_nettype wire

// File: tb/tb_cnn_accel_top.sv
// ============================================================================
// tb_cnn_accel_top - directed self-checking bench for cnn_accel_top
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_cnn_accel_top;

    localparam int MAC_NUM = 256;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [31:0]            tdata;
    logic [3:0]             tstrb;
    logic                   tlast, tvalid, tready;
    logic [3:0]             awaddr, araddr;
    logic [2:0]             awprot, arprot;
    logic                   awvalid, awready, wvalid, wready, bvalid, bready;
    logic                   arvalid, arready, rvalid, rready;
    logic [31:0]            wdata, rdata;
    logic [3:0]             wstrb;
    logic [1:0]             bresp, rresp;
    logic [MAC_NUM*5-1:0]   psum_out;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cnn_accel_top #(
        .MAC_NUM              (MAC_NUM),
        .BRAM_ADDRESS_WIDTH   (12),
        .C_S_AXIS_TDATA_WIDTH (32),
        .C_S_AXI_DATA_WIDTH   (32),
        .C_S_AXI_ADDR_WIDTH   (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .S_AXIS_TDATA  (tdata),
        .S_AXIS_TSTRB  (tstrb),
        .S_AXIS_TLAST  (tlast),
        .S_AXIS_TVALID (tvalid),
        .S_AXIS_TREADY (tready),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWPROT  (awprot),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARPROT  (arprot),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready),
        .psum_out      (psum_out)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] lane(input int i);
        return 32'(psum_out[i*5 +: 5]);
    endfunction

    // VALIDs stay up two extra cycles after BVALID to expose any double acceptance.
    task automatic axi_write(input string tag, input logic [3:0] addr,
                             input logic [31:0] data, input logic [3:0] strb);
        int acc = 0;
        int cyc = 0;
        @(negedge clk);
        awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
        while (!bvalid && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (awready && wready) acc++;
        end
        repeat (2) begin
            @(negedge clk);
            if (awready || wready) acc++;
        end
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        check({tag, "_accepts"}, 32'(acc) + (bvalid ? 32'd100 : 32'd0), 32'd1);
    endtask

    task automatic axi_read_check(input string tag, input logic [3:0] addr,
                                  input logic [31:0] exp);
        int          cyc = 0;
        logic [31:0] data;
        @(negedge clk);
        araddr = addr; arvalid = 1'b1;
        while (!rvalid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        data = rvalid ? rdata : 32'hDEAD_BEEF;
        arvalid = 1'b0; rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
        check(tag, data, exp);
    endtask

    task automatic send_beat(input logic [4:0] b);
        int cyc = 0;
        @(negedge clk);
        tdata = {27'h7FF_FFFF, b}; tvalid = 1'b1;
        while (!tready && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("beat_tready", 32'(tready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        tvalid = 1'b0;
    endtask

    logic [4:0] kern_b [5] = '{5'b11111, 5'b10111, 5'b11101, 5'b11011, 5'b10001};
    logic [4:0] ifm_b  [6] = '{5'b11111, 5'b01111, 5'b10111, 5'b11011, 5'b11101, 5'b11110};

    initial begin
        rst_n = 1'b0; tdata = '0; tstrb = 4'hF; tlast = 1'b0; tvalid = 1'b0;
        awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
        bready = 1'b0; araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_tready", 32'(tready), 32'd0);
        check("rst_axi_outs", {27'd0, awready, wready, bvalid, arready, rvalid}, 32'd0);
        check("rst_psum", 32'(|psum_out), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("tready_after_rst", 32'(tready), 32'd1);

        axi_read_check("rd_ctrl0_rst", 4'h0, 32'd0);
        axi_read_check("rd_ctrl1_rst", 4'h4, 32'd0);
        axi_read_check("rd_ctrl2_rst", 4'h8, 32'd0);

        // K=5 conv, ofmaps_channel=1, input_channel=2, width=3 -> N=3
        axi_write("wr_ctrl2", 4'h8, 32'h0000_0010, 4'b1111);
        axi_write("wr_ctrl0", 4'h0, 32'h0010_02AA, 4'b1110);
        axi_write("wr_ctrl1", 4'h4, 32'h0000_000C, 4'b1111);
        axi_read_check("rb_ctrl0", 4'h0, 32'h0010_0200);
        axi_read_check("rb_ctrl1", 4'h4, 32'h0000_000C);
        axi_read_check("rb_ctrl2", 4'h8, 32'h0000_0010);

        for (int i = 0; i < 5; i++) send_beat(kern_b[i]);
        axi_write("wr_start_conv", 4'h0, 32'h0000_0057, 4'b0001);
        axi_read_check("status_compute", 4'hC, 32'h0000_0002);
        for (int i = 0; i < 5; i++) send_beat(ifm_b[i]);
        check("conv_lane0", lane(0), 32'd17);
        check("conv_lane1_untouched", lane(1), 32'd0);
        send_beat(ifm_b[5]);
        check("conv_lane1", lane(1), 32'd15);
        axi_read_check("status_mid", 4'hC, 32'h0000_0002);
        send_beat(5'b00000);
        check("conv_lane2", lane(2), 32'd14);
        axi_read_check("status_done", 4'hC, 32'h0000_0001);
        axi_read_check("ctrl0_instr_cleared", 4'h0, 32'h0010_0200);
        axi_read_check("ctrl2_done", 4'h8, 32'h0000_0030);

        // Pooling over the same stream
        axi_write("wr_ctrl1_pool", 4'h4, 32'h0000_000D, 4'b1111);
        for (int i = 0; i < 5; i++) send_beat(kern_b[i]);
        axi_write("wr_start_pool", 4'h0, 32'h0000_0057, 4'b0001);
        axi_read_check("ctrl2_done_cleared", 4'h8, 32'h0000_0010);
        for (int i = 0; i < 6; i++) send_beat(ifm_b[i]);
        send_beat(5'b00000);
        check("pool_lane0", lane(0), 32'd1);
        check("pool_lane1", lane(1), 32'd1);
        check("pool_lane2", lane(2), 32'd1);
        axi_read_check("pool_status_done", 4'hC, 32'h0000_0001);

        // Pooling over an all-zero window
        axi_write("wr_start_pool0", 4'h0, 32'h0000_0057, 4'b0001);
        for (int i = 0; i < 7; i++) send_beat(5'b00000);
        check("pool0_lane0", lane(0), 32'd0);
        check("pool0_lane1", lane(1), 32'd0);
        check("pool0_lane2", lane(2), 32'd0);
        check("pool0_lane3", lane(3), 32'd0);

        // K=3 conv with ofmaps_width=0 -> a single psum; stray high bits are ignored
        axi_write("wr_ctrl1_k3", 4'h4, 32'h0000_0000, 4'b1111);
        axi_write("wr_ctrl2_k3", 4'h8, 32'h0000_0004, 4'b1111);
        send_beat(5'b11101);
        send_beat(5'b11111);
        send_beat(5'b11011);
        axi_write("wr_start_k3", 4'h0, 32'h0000_0057, 4'b0001);
        for (int i = 0; i < 3; i++) send_beat(5'b11111);
        check("k3_lane0", lane(0), 32'd7);
        axi_read_check("k3_status_done", 4'hC, 32'h0000_0001);

        // Reset in the middle of a compute
        axi_write("wr_ctrl1_rst", 4'h4, 32'h0000_000C, 4'b1111);
        axi_write("wr_ctrl2_rst", 4'h8, 32'h0000_0010, 4'b1111);
        axi_write("wr_start_rst", 4'h0, 32'h0000_0057, 4'b0001);
        send_beat(5'b10101);
        send_beat(5'b01010);
        axi_read_check("status_before_rst", 4'hC, 32'h0000_0002);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_psum", 32'(|psum_out), 32'd0);
        check("midrst_tready", 32'(tready), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        axi_read_check("midrst_ctrl0", 4'h0, 32'd0);
        axi_read_check("midrst_ctrl1", 4'h4, 32'd0);
        axi_read_check("midrst_ctrl2", 4'h8, 32'd0);
        axi_read_check("midrst_status", 4'hC, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
